reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose register file for the single-cycle datapath, directly upstream of the ALU.
- Two combinational read ports drive the ALU's two 32-bit operand inputs (dataIn1, dataIn2).
- One synchronous write port takes the writeback result (ALU dataOut or load data) at the end of each instruction's cycle.
- Optional same-cycle write-to-read bypass, for later pipelined reuse.

Parameters:
- DATA_WIDTH, 32: register and data width in bits.
- ADDR_WIDTH, 4: register address width.
- NUM_REGS, 16: number of registers; must equal 2**ADDR_WIDTH.
- ZERO_R0, 0: when 1, register 0 reads as 0 and ignores writes.
- BYPASS, 0: when 1, a read of the register being written this cycle returns the write data.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- srcAddr1  in  ADDR_WIDTH  read port 1 address.
- srcAddr2  in  ADDR_WIDTH  read port 2 address.
- dataOut1  out  DATA_WIDTH  read port 1 data; feeds ALU dataIn1.
- dataOut2  out  DATA_WIDTH  read port 2 data; feeds ALU dataIn2 (through the immediate mux).
- wrEn  in  1  write enable.
- wrAddr  in  ADDR_WIDTH  write address.
- wrData  in  DATA_WIDTH  write data (writeback value).
- wrCount  out  16  count of committed writes, for bench/debug.

Behaviour:
- Storage: NUM_REGS x DATA_WIDTH flops.
- Reset: on a rising clk edge with rst_n=0:
  - every register is cleared to 0 and wrCount to 0;
  - wrEn is ignored on that edge, even if asserted.
- Reset is synchronous only: asserting rst_n=0 between edges changes nothing until the next edge.
- Reset mid-program: all contents are lost. The first edge with rst_n=1 behaves normally; there is no recovery delay.
- Read ports are purely combinational, with no clock latency.
  - dataOut1 = reg[srcAddr1]; dataOut2 = reg[srcAddr2].
  - Outputs settle in the same cycle as an address change.
- Read during reset: outputs show the current array contents. After the reset edge, every read returns 0.
- Write: on a rising edge with rst_n=1 and wrEn=1, reg[wrAddr] <= wrData.
  - The new value is visible on read ports after that edge (next cycle).
  - wrEn=0 leaves the array and wrCount unchanged.
- wrCount increments by 1 per committed write and wraps 0xFFFF -> 0x0000.
  - A write to r0 while ZERO_R0=1 is discarded and does not count.
- ZERO_R0=1:
  - reads of address 0 return 0 regardless of array contents;
  - writes to address 0 are discarded.
- BYPASS=0 (single-cycle default): a same-cycle read of wrAddr returns the OLD value. This is correct for single-cycle writeback at the end of the instruction.
- BYPASS=1:
  - if wrEn=1 and rst_n=1 and srcAddrN==wrAddr, dataOutN = wrData combinationally;
  - both ports bypass independently, and both may bypass simultaneously;
  - the ZERO_R0 rule takes priority: address 0 still reads 0.
- Both read ports may address the same register; both return the identical value.
- No X propagation: every register has a defined value after the first reset edge.
- Width rules: addresses are used directly with no masking. NUM_REGS must equal 2**ADDR_WIDTH, so no out-of-range address exists.

Test Plan:
1. Reset clears state: write 0xDEADBEEF to r5, then hold rst_n=0 for one edge with wrEn=1, wrAddr=7, wrData=0x1234 -> r5 and r7 read 0x00000000; wrCount=0.
2. Write then read: wrEn=1, wrAddr=3, wrData=0x0000FFFF, then wrAddr=9, wrData=0xA5A5A5A5 -> next cycle srcAddr1=3, srcAddr2=9 give dataOut1=0x0000FFFF, dataOut2=0xA5A5A5A5; wrCount=2.
3. Same-cycle read of the write target, BYPASS=0: r4=0x11111111; drive wrAddr=4, wrData=0x22222222, srcAddr1=4 -> dataOut1=0x11111111 before the edge, 0x22222222 after. With BYPASS=1 -> 0x22222222 before the edge, on both ports if srcAddr2=4.
4. ZERO_R0=1: write 0xFFFFFFFF to r0 -> dataOut1 (srcAddr1=0) = 0; wrCount unchanged. With ZERO_R0=0 the same sequence reads 0xFFFFFFFF.
5. wrEn=0 hold: r2=0x00000042; drive wrEn=0, wrAddr=2, wrData=0x99 for 5 cycles -> r2 stays 0x00000042; wrCount unchanged.
6. wrCount wrap: 65536 consecutive writes from reset -> wrCount=0x0000; reads remain correct for the last data written; a mid-stream reset returns wrCount to 0 on the next edge.

Source files
------------

// File: rtl/reg_file.sv
// General-purpose register file: two combinational read ports, one synchronous
// write port, optional r0-hardwired-to-zero and same-cycle write-to-read bypass.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 16,
  parameter bit ZERO_R0    = 1'b0,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] srcAddr1,
  input  logic [ADDR_WIDTH-1:0] srcAddr2,
  output logic [DATA_WIDTH-1:0] dataOut1,
  output logic [DATA_WIDTH-1:0] dataOut2,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic [15:0]           wrCount
);

  if (NUM_REGS != (1 << ADDR_WIDTH)) begin : gBadSize
    $error("reg_file: NUM_REGS must equal 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  commit;

  // A write aimed at a hardwired-zero r0 is dropped entirely, including from wrCount.
  assign commit = wrEn && !(ZERO_R0 && (wrAddr == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wrCount <= '0;
    end else if (commit) begin
      regs[wrAddr] <= wrData;
      wrCount      <= wrCount + 16'd1;
    end
  end

  // Zero-r0 is applied last so it overrides a bypassed write to address 0.
  always_comb begin
    dataOut1 = regs[srcAddr1];
    if (BYPASS && wrEn && rst_n && (srcAddr1 == wrAddr)) begin
      dataOut1 = wrData;
    end
    if (ZERO_R0 && (srcAddr1 == '0)) begin
      dataOut1 = '0;
    end
  end

  always_comb begin
    dataOut2 = regs[srcAddr2];
    if (BYPASS && wrEn && rst_n && (srcAddr2 == wrAddr)) begin
      dataOut2 = wrData;
    end
    if (ZERO_R0 && (srcAddr2 == '0)) begin
      dataOut2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a default instance (no zero-r0, no bypass) and a
// zero-r0 + bypass instance share one stimulus stream and one reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  srcAddr1 = '0;
  logic [3:0]  srcAddr2 = '0;
  logic        wrEn = 1'b0;
  logic [3:0]  wrAddr = '0;
  logic [31:0] wrData = '0;

  logic [31:0] dOut1A, dOut2A, dOut1B, dOut2B;
  logic [15:0] cntA, cntB;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: plain register arrays and write counters.
  logic [31:0] memA [16];
  logic [31:0] memB [16];
  logic [15:0] modelCntA = '0;
  logic [15:0] modelCntB = '0;

  always #5 clk = ~clk;

  reg_file #(.ZERO_R0(1'b0), .BYPASS(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .srcAddr1(srcAddr1), .srcAddr2(srcAddr2),
    .dataOut1(dOut1A), .dataOut2(dOut2A), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrData(wrData), .wrCount(cntA)
  );

  reg_file #(.ZERO_R0(1'b1), .BYPASS(1'b1)) dutB (
    .clk(clk), .rst_n(rst_n), .srcAddr1(srcAddr1), .srcAddr2(srcAddr2),
    .dataOut1(dOut1B), .dataOut2(dOut2B), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrData(wrData), .wrCount(cntB)
  );

  // Expected read of the zero-r0 + bypass instance, from the rules directly.
  function automatic logic [31:0] expB(input logic [3:0] addr);
    if (addr == 4'd0) return 32'h0;
    if (wrEn && rst_n && addr == wrAddr) return wrData;
    return memB[addr];
  endfunction

  // Apply the current inputs at the next rising edge, updating the model with them.
  task automatic step();
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        memA[i] = 32'h0;
        memB[i] = 32'h0;
      end
      modelCntA = 16'h0;
      modelCntB = 16'h0;
    end else if (wrEn) begin
      memA[wrAddr] = wrData;
      modelCntA = modelCntA + 16'h1;
      if (wrAddr != 4'd0) begin
        memB[wrAddr] = wrData;
        modelCntB = modelCntB + 16'h1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wrEn = 1'b1; wrAddr = 4'd7; wrData = 32'h1234;
    srcAddr1 = 4'd7; srcAddr2 = 4'd5;
    step();
    rst_n = 1'b1; wrEn = 1'b0;
    @(negedge clk);
    vectors++; if (dOut1A !== 32'h0 || dOut2A !== 32'h0) begin
      miscompares++; $display("FAIL reset_first_a: got %h/%h expected 0/0", dOut1A, dOut2A); end
    vectors++; if (dOut1B !== 32'h0 || dOut2B !== 32'h0) begin
      miscompares++; $display("FAIL reset_first_b: got %h/%h expected 0/0", dOut1B, dOut2B); end
    vectors++; if (cntA !== 16'h0 || cntB !== 16'h0) begin
      miscompares++; $display("FAIL reset_first_cnt: got %h/%h expected 0/0", cntA, cntB); end
    wrEn = 1'b1; wrAddr = 4'd5; wrData = 32'hDEADBEEF;
    step();
    wrEn = 1'b0;
    @(negedge clk);
    vectors++; if (dOut2A !== 32'hDEADBEEF || dOut2B !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL reset_prewrite: got %h/%h expected deadbeef", dOut2A, dOut2B); end
    // Reset asserted between edges, with a write to r5 pending: nothing moves yet.
    rst_n = 1'b0; wrEn = 1'b1; wrAddr = 4'd5; wrData = 32'h1234; srcAddr1 = 4'd5;
    #1;
    vectors++; if (dOut1A !== 32'hDEADBEEF || dOut1B !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL reset_async_rd: got %h/%h expected deadbeef", dOut1A, dOut1B); end
    vectors++; if (cntA !== 16'h1 || cntB !== 16'h1) begin
      miscompares++; $display("FAIL reset_async_cnt: got %h/%h expected 1/1", cntA, cntB); end
    wrAddr = 4'd7;
    step();
    rst_n = 1'b1; wrEn = 1'b0; srcAddr1 = 4'd7; srcAddr2 = 4'd5;
    @(negedge clk);
    vectors++; if (dOut1A !== 32'h0 || dOut2A !== 32'h0 || dOut1B !== 32'h0 || dOut2B !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_clear: got %h %h %h %h expected all 0", dOut1A, dOut2A, dOut1B, dOut2B);
    end
    vectors++; if (cntA !== 16'h0 || cntB !== 16'h0) begin
      miscompares++; $display("FAIL reset_clear_cnt: got %h/%h expected 0/0", cntA, cntB); end
  endtask

  task automatic test_write_read();
    wrEn = 1'b1; wrAddr = 4'd3; wrData = 32'h0000FFFF;
    step();
    wrAddr = 4'd9; wrData = 32'hA5A5A5A5;
    step();
    wrEn = 1'b0; srcAddr1 = 4'd3; srcAddr2 = 4'd9;
    @(negedge clk);
    vectors++; if (dOut1A !== 32'h0000FFFF || dOut1B !== 32'h0000FFFF) begin
      miscompares++; $display("FAIL wr_rd_port1: got %h/%h expected 0000ffff", dOut1A, dOut1B); end
    vectors++; if (dOut2A !== 32'hA5A5A5A5 || dOut2B !== 32'hA5A5A5A5) begin
      miscompares++; $display("FAIL wr_rd_port2: got %h/%h expected a5a5a5a5", dOut2A, dOut2B); end
    vectors++; if (cntA !== 16'h2 || cntB !== 16'h2) begin
      miscompares++; $display("FAIL wr_rd_cnt: got %h/%h expected 2/2", cntA, cntB); end
    srcAddr2 = 4'd3;
    #1;
    vectors++; if (dOut2A !== 32'h0000FFFF || dOut2B !== dOut1B || dOut2A !== dOut1A) begin
      miscompares++; $display("FAIL same_addr_both: got %h %h %h %h expected 0000ffff", dOut1A, dOut2A, dOut1B, dOut2B); end
  endtask

  task automatic test_bypass();
    wrEn = 1'b1; wrAddr = 4'd4; wrData = 32'h11111111;
    step();
    wrData = 32'h22222222; srcAddr1 = 4'd4; srcAddr2 = 4'd4;
    @(negedge clk);
    vectors++; if (dOut1A !== 32'h11111111 || dOut2A !== 32'h11111111) begin
      miscompares++; $display("FAIL nobypass_old: got %h/%h expected 11111111", dOut1A, dOut2A); end
    vectors++; if (dOut1B !== 32'h22222222 || dOut2B !== 32'h22222222) begin
      miscompares++; $display("FAIL bypass_both: got %h/%h expected 22222222", dOut1B, dOut2B); end
    step();
    wrAddr = 4'd6; wrData = 32'h33333333; srcAddr2 = 4'd6;
    @(negedge clk);
    vectors++; if (dOut1A !== 32'h22222222 || dOut1B !== 32'h22222222) begin
      miscompares++; $display("FAIL bypass_after_edge: got %h/%h expected 22222222", dOut1A, dOut1B); end
    vectors++; if (dOut2B !== 32'h33333333 || dOut2A !== memA[6]) begin
      miscompares++; $display("FAIL bypass_port2_only: got %h/%h expected 33333333/%h", dOut2B, dOut2A, memA[6]); end
    step();
    wrEn = 1'b0;
  endtask

  task automatic test_zero_r0();
    logic [15:0] savedB;
    savedB = modelCntB;
    wrEn = 1'b1; wrAddr = 4'd0; wrData = 32'hFFFFFFFF; srcAddr1 = 4'd0; srcAddr2 = 4'd0;
    @(negedge clk);
    vectors++; if (dOut1B !== 32'h0 || dOut2B !== 32'h0) begin
      miscompares++; $display("FAIL zero_r0_bypass: got %h/%h expected 0", dOut1B, dOut2B); end
    vectors++; if (dOut1A !== memA[0]) begin
      miscompares++; $display("FAIL r0_old_a: got %h expected %h", dOut1A, memA[0]); end
    step();
    wrEn = 1'b0;
    @(negedge clk);
    vectors++; if (dOut1A !== 32'hFFFFFFFF) begin
      miscompares++; $display("FAIL r0_write_a: got %h expected ffffffff", dOut1A); end
    vectors++; if (dOut1B !== 32'h0) begin
      miscompares++; $display("FAIL zero_r0_read: got %h expected 0", dOut1B); end
    vectors++; if (cntB !== savedB || cntA !== modelCntA) begin
      miscompares++; $display("FAIL zero_r0_cnt: got %h/%h expected %h/%h", cntA, cntB, modelCntA, savedB); end
  endtask

  task automatic test_hold();
    logic [15:0] savedA, savedB;
    wrEn = 1'b1; wrAddr = 4'd2; wrData = 32'h00000042;
    step();
    savedA = modelCntA; savedB = modelCntB;
    wrEn = 1'b0; wrData = 32'h99; srcAddr1 = 4'd2; srcAddr2 = 4'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++; if (dOut1A !== 32'h42 || dOut1B !== 32'h42 || dOut2B !== 32'h42) begin
        miscompares++; $display("FAIL hold_data c%0d: got %h/%h/%h expected 42", c, dOut1A, dOut1B, dOut2B); end
      vectors++; if (cntA !== savedA || cntB !== savedB) begin
        miscompares++; $display("FAIL hold_cnt c%0d: got %h/%h expected %h/%h", c, cntA, cntB, savedA, savedB); end
      step();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 24) != 0);
      wrEn = ($urandom_range(0, 3) != 0);
      wrAddr = 4'($urandom_range(0, 15));
      wrData = $urandom;
      srcAddr1 = ($urandom_range(0, 3) == 0) ? wrAddr : 4'($urandom_range(0, 15));
      srcAddr2 = ($urandom_range(0, 3) == 0) ? wrAddr : 4'($urandom_range(0, 15));
      @(negedge clk);
      vectors++; if (dOut1A !== memA[srcAddr1] || dOut2A !== memA[srcAddr2]) begin
        miscompares++;
        $display("FAIL rand_a n%0d: got %h/%h expected %h/%h", n, dOut1A, dOut2A, memA[srcAddr1], memA[srcAddr2]);
      end
      vectors++; if (dOut1B !== expB(srcAddr1) || dOut2B !== expB(srcAddr2)) begin
        miscompares++;
        $display("FAIL rand_b n%0d: got %h/%h expected %h/%h", n, dOut1B, dOut2B, expB(srcAddr1), expB(srcAddr2));
      end
      vectors++; if (cntA !== modelCntA || cntB !== modelCntB) begin
        miscompares++; $display("FAIL rand_cnt n%0d: got %h/%h expected %h/%h", n, cntA, cntB, modelCntA, modelCntB); end
      step();
    end
    rst_n = 1'b1; wrEn = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0]  lastAddr;
    logic [31:0] lastData;
    lastAddr = 4'd1; lastData = 32'h0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; wrEn = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      wrAddr = 4'($urandom_range(1, 15));
      wrData = $urandom;
      lastAddr = wrAddr; lastData = wrData;
      if (i == 65535) begin
        @(negedge clk);
        vectors++; if (cntA !== 16'hFFFF || cntB !== 16'hFFFF) begin
          miscompares++; $display("FAIL wrap_pre: got %h/%h expected ffff", cntA, cntB); end
      end
      step();
    end
    wrEn = 1'b0; srcAddr1 = lastAddr; srcAddr2 = 4'($urandom_range(1, 15));
    @(negedge clk);
    vectors++; if (cntA !== 16'h0 || cntB !== 16'h0) begin
      miscompares++; $display("FAIL wrap_zero: got %h/%h expected 0000", cntA, cntB); end
    vectors++; if (dOut1A !== lastData || dOut1B !== lastData) begin
      miscompares++; $display("FAIL wrap_last_rd: got %h/%h expected %h", dOut1A, dOut1B, lastData); end
    vectors++; if (dOut2A !== memA[srcAddr2] || dOut2B !== memB[srcAddr2]) begin
      miscompares++; $display("FAIL wrap_other_rd: got %h/%h expected %h", dOut2A, dOut2B, memA[srcAddr2]); end
    wrEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wrAddr = 4'($urandom_range(1, 15)); wrData = $urandom;
      step();
    end
    @(negedge clk);
    vectors++; if (cntA !== 16'h3 || cntB !== 16'h3) begin
      miscompares++; $display("FAIL midstream_pre: got %h/%h expected 3", cntA, cntB); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; wrEn = 1'b0;
    @(negedge clk);
    vectors++; if (cntA !== 16'h0 || cntB !== 16'h0) begin
      miscompares++; $display("FAIL midstream_reset: got %h/%h expected 0", cntA, cntB); end
    wrEn = 1'b1; wrAddr = 4'd8; wrData = 32'hCAFEF00D; srcAddr1 = 4'd8;
    step();
    wrEn = 1'b0;
    @(negedge clk);
    vectors++; if (cntA !== 16'h1 || dOut1A !== 32'hCAFEF00D || dOut1B !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL post_reset_write: got %h %h %h expected 1 cafef00d", cntA, dOut1A, dOut1B); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_r0();
    test_hold();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
